lfsr_decoder: RTL



---
 rtl/lfsr_pkg.sv | 39 +++
 rtl/lfsr_decoder_core.sv | 25 ++
 rtl/lfsr_decoder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: candidate taps, padding byte, header layout,
// decoder state encoding and the single-step LFSR function.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned NTAPS  = 8;

    localparam logic [LFSR_W-1:0] PAD_CHAR = 8'hA0;

    // Candidate taps, tried in index order.
    localparam logic [LFSR_W-1:0] TAP_LIST [NTAPS] = '{
        8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3
    };

    localparam int unsigned ENC_BASE = 64;
    localparam int unsigned HDR_PAD  = 61;
    localparam int unsigned HDR_TAP  = 62;
    localparam int unsigned HDR_SEED = 63;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEED,
        ST_CHECK,
        ST_NEXT_TAP,
        ST_DECODE_INIT,
        ST_DECODE,
        ST_HDR,
        ST_DONE,
        ST_FAIL
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] tap
    );
        return {s[LFSR_W-2:0], ^(s & tap)};
    endfunction

endpackage

// File: rtl/lfsr_decoder_core.sv
// Keystream register: loadable LFSR state with a one-step lookahead output.
module lfsr_decoder_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              en,
    input  logic [LFSR_W-1:0] tap,
    output logic [LFSR_W-1:0] s,
    output logic [LFSR_W-1:0] s_next
);

    assign s_next = lfsr_step(s, tap);

    // Load has priority over stepping.
    always_ff @(posedge clk) begin
        if (load) begin
            s <= load_val;
        end else if (en) begin
            s <= s_next;
        end
    end

endmodule

// File: rtl/lfsr_decoder.sv
// LFSR block decoder: recovers tap/seed from the padding preamble, strips the
// padding, writes plaintext to dmem[0..] and the header to dmem[61..63].
module lfsr_decoder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NCHK     = 7,
    parameter int unsigned ENC_BASE = lfsr_pkg::ENC_BASE,
    parameter int unsigned MSG_LEN  = 64
) (
    input  logic              clk,
    input  logic              init,
    output logic [ADDR_W-1:0] raddr,
    input  logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W-1:0] waddr,
    output logic [WIDTH-1:0]  wdata,
    output logic              wen,
    output logic              done,
    output logic              fail
);
    import lfsr_pkg::*;

    state_t            state;
    state_t            state_nx;
    logic [2:0]        tap_idx;
    logic [6:0]        cnt;
    logic [6:0]        pad_cnt;
    logic [ADDR_W-1:0] wptr;
    logic              in_msg;
    logic [WIDTH-1:0]  seed;

    logic [WIDTH-1:0]  cur_tap;
    logic [WIDTH-1:0]  s;
    logic [WIDTH-1:0]  s_next;
    logic              s_load;
    logic [WIDTH-1:0]  s_load_val;
    logic              s_en;
    logic              wr;
    logic [WIDTH-1:0]  p;

    assign cur_tap = TAP_LIST[tap_idx];
    assign p       = rdata ^ s;

    lfsr_decoder_core u_core (
        .clk      (clk),
        .load     (s_load),
        .load_val (s_load_val),
        .en       (s_en),
        .tap      (cur_tap),
        .s        (s),
        .s_next   (s_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (init) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, keystream control and write-port outputs.
    always_comb begin
        state_nx   = state;
        s_load     = 1'b0;
        s_load_val = seed;
        s_en       = 1'b0;
        wr         = 1'b0;
        waddr      = wptr;
        wdata      = p;
        case (state)
            ST_IDLE: state_nx = ST_SEED;
            ST_SEED: begin
                s_load     = 1'b1;
                s_load_val = rdata ^ PAD_CHAR;
                state_nx   = ST_CHECK;
            end
            ST_CHECK: begin
                // Byte k is compared against S[k], i.e. one step ahead of s.
                if ((rdata ^ s_next) != PAD_CHAR) begin
                    state_nx = ST_NEXT_TAP;
                end else begin
                    s_en = 1'b1;
                    if (cnt == 7'(NCHK)) state_nx = ST_DECODE_INIT;
                end
            end
            ST_NEXT_TAP: state_nx = (tap_idx == 3'(NTAPS - 1)) ? ST_FAIL : ST_SEED;
            ST_DECODE_INIT: begin
                s_load     = 1'b1;
                s_load_val = seed;
                state_nx   = ST_DECODE;
            end
            ST_DECODE: begin
                s_en = 1'b1;
                wr   = in_msg || (p != PAD_CHAR);
                if (cnt == 7'(MSG_LEN - 1)) state_nx = ST_HDR;
            end
            ST_HDR: begin
                wr = 1'b1;
                case (cnt)
                    7'd0: begin
                        waddr = ADDR_W'(HDR_PAD);
                        wdata = WIDTH'(pad_cnt);
                    end
                    7'd1: begin
                        waddr = ADDR_W'(HDR_TAP);
                        wdata = cur_tap;
                    end
                    default: begin
                        waddr = ADDR_W'(HDR_SEED);
                        wdata = seed;
                    end
                endcase
                if (cnt == 7'd2) state_nx = ST_DONE;
            end
            default: state_nx = state;
        endcase
        // init aborts writes and status in the same cycle it is raised.
        wen  = wr && !init;
        done = !init && ((state == ST_DONE) || (state == ST_FAIL));
        fail = !init && (state == ST_FAIL);
    end

    // Address, counter, tap index and header registers.
    always_ff @(posedge clk) begin
        if (init) begin
            raddr   <= ADDR_W'(ENC_BASE);
            tap_idx <= '0;
            cnt     <= '0;
            pad_cnt <= '0;
            wptr    <= '0;
            in_msg  <= 1'b0;
            seed    <= '0;
        end else begin
            case (state)
                ST_IDLE: raddr <= ADDR_W'(ENC_BASE);
                ST_SEED: begin
                    seed  <= rdata ^ PAD_CHAR;
                    cnt   <= 7'd1;
                    raddr <= raddr + ADDR_W'(1);
                end
                ST_CHECK: begin
                    cnt   <= cnt + 7'd1;
                    raddr <= raddr + ADDR_W'(1);
                end
                ST_NEXT_TAP: begin
                    if (tap_idx != 3'(NTAPS - 1)) tap_idx <= tap_idx + 3'd1;
                    raddr <= ADDR_W'(ENC_BASE);
                end
                ST_DECODE_INIT: begin
                    raddr   <= ADDR_W'(ENC_BASE);
                    pad_cnt <= '0;
                    wptr    <= '0;
                    in_msg  <= 1'b0;
                    cnt     <= '0;
                end
                ST_DECODE: begin
                    raddr <= raddr + ADDR_W'(1);
                    cnt   <= (cnt == 7'(MSG_LEN - 1)) ? 7'd0 : cnt + 7'd1;
                    if (wr) begin
                        wptr   <= wptr + ADDR_W'(1);
                        in_msg <= 1'b1;
                    end else begin
                        pad_cnt <= pad_cnt + 7'd1;
                    end
                end
                ST_HDR: cnt <= cnt + 7'd1;
                default: ;
            endcase
        end
    end

endmodule
